pc_sequencer: RTL

Fetch-side controller that owns the program counter register and sequences the next-PC datapath of the five-stage MIPS pipeline. Each cycle it chooses between the sequential path (pc+4) and a redirect target produced by the ID-stage next-PC/branch logic. It honours hazard-unit stalls and a multi-cycle instruction-memory acknowledge, and latches any redirect that cannot be applied immediately. It sits between the hazard unit, the ID-stage next-PC logic, the instruction memory and the IF/ID pipeline register.

---
 rtl/pc_pkg.sv | 22 ++
 rtl/redir_counter.sv | 47 ++++
 rtl/pc_sequencer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// pc_pkg: shared definitions for the fetch-side PC sequencer.
//   - pc_state_e  : sequencer state (BOOT, RUN, PEND)
//   - PC_RESET_DEFAULT : default PC loaded on reset
//   - INSN_BYTES  : instruction-word size in bytes (sequential PC step)
//   - align_word(): forces a byte address onto an instruction-word boundary
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } pc_state_e;

    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] INSN_BYTES       = 32'd4;

    // Drop the byte-offset bits so the PC always points at a whole word.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/redir_counter.sv
// redir_counter: saturating event counter for applied redirects.
// Ports:
//   clk   in  1      rising-edge clock
//   reset in  1      asynchronous active-high reset (count -> 0)
//   clr   in  1      synchronous clear (count -> 0), wins over inc
//   inc   in  1      count one event this cycle
//   cnt   out CNT_W  current count, holds at all-ones
module redir_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    // Next count: clear, saturating increment, or hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the fetch PC and selects between pc+4 and an ID-stage
// redirect target, honouring hazard stalls and a multi-cycle IM acknowledge.
// A redirect that arrives while the current fetch is still outstanding is
// parked in tgt_q (state PEND) and applied on the next advancing cycle.
//
// Build option: define PC_SEQ_DELAY_SLOT_EN for MIPS delay-slot semantics
// (flush_if tied low). Undefined: flush_if squashes the wrong-path word.
//
// Ports:
//   clk        in  1      rising-edge clock
//   reset      in  1      asynchronous active-high reset
//   stall      in  1      hazard freeze of PC and IF/ID
//   if_ack     in  1      IM returned the word for pc this cycle
//   br_valid   in  1      ID resolved a branch/jump (ignored under stall)
//   br_taken   in  1      resolved branch/jump changes flow
//   br_target  in  32     redirect target address
//   pc         out 32     current fetch address
//   pc_plus4   out 32     pc + 4 (wraps)
//   if_req     out 1      fetch request to IM
//   if_valid   out 1      IF/ID may capture the fetched word
//   flush_if   out 1      squash the word captured into IF/ID this cycle
//   addr_err   out 1      sticky: misaligned redirect target accepted
//   redir_cnt  out CNT_W  saturating count of taken redirects
module pc_sequencer
    import pc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = PC_RESET_DEFAULT,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             if_ack,
    input  logic             br_valid,
    input  logic             br_taken,
    input  logic [31:0]      br_target,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    output logic             if_req,
    output logic             if_valid,
    output logic             flush_if,
    output logic             addr_err,
    output logic [CNT_W-1:0] redir_cnt
);

    pc_state_e   state_q;
    pc_state_e   state_d;
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] tgt_q;
    logic [31:0] tgt_d;
    logic        addr_err_q;
    logic        addr_err_d;

    logic        req_s;
    logic        adv_s;
    logic        take_s;
    logic        redirect_s;
    logic [31:0] br_aligned_s;
    logic [31:0] pc_plus4_s;

    // Handshake qualifiers shared by the FSM, counter and error flag.
    always_comb begin
        req_s        = (state_q != BOOT);
        adv_s        = req_s & if_ack & ~stall;
        take_s       = br_valid & br_taken & ~stall;
        br_aligned_s = align_word(br_target);
        pc_plus4_s   = pc_q + INSN_BYTES;
    end

    // Next-state / next-PC selection.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        tgt_d      = tgt_q;
        redirect_s = 1'b0;
        case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                if (take_s) begin
                    if (adv_s) begin
                        pc_d       = br_aligned_s;
                        redirect_s = 1'b1;
                    end else begin
                        // Fetch still outstanding: park the target.
                        tgt_d   = br_aligned_s;
                        state_d = PEND;
                    end
                end else if (adv_s) begin
                    pc_d = pc_plus4_s;
                end else begin
                    pc_d = pc_q;
                end
            end
            PEND: begin
                // A newer redirect replaces the parked one.
                if (take_s) begin
                    tgt_d = br_aligned_s;
                end else begin
                    tgt_d = tgt_q;
                end
                if (adv_s) begin
                    pc_d       = take_s ? br_aligned_s : tgt_q;
                    state_d    = RUN;
                    redirect_s = 1'b1;
                end else begin
                    pc_d = pc_q;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // Sticky misaligned-target flag; only reset clears it.
    always_comb begin
        if (take_s && (br_target[1:0] != 2'b00)) begin
            addr_err_d = 1'b1;
        end else begin
            addr_err_d = addr_err_q;
        end
    end

    // Sequencer state, PC, parked target and error flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            tgt_q      <= 32'h0000_0000;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            tgt_q      <= tgt_d;
            addr_err_q <= addr_err_d;
        end
    end

    redir_counter #(
        .CNT_W (CNT_W)
    ) u_redir_counter (
        .clk   (clk),
        .reset (reset),
        .clr   (1'b0),
        .inc   (take_s),
        .cnt   (redir_cnt)
    );

    assign pc       = pc_q;
    assign pc_plus4 = pc_plus4_s;
    assign if_req   = req_s;
    assign if_valid = adv_s;
    assign addr_err = addr_err_q;

`ifdef PC_SEQ_DELAY_SLOT_EN
    // Delay slot: the word after the branch executes, nothing is squashed.
    assign flush_if = 1'b0;
`else
    // No delay slot: the wrong-path word entering IF/ID becomes a bubble.
    assign flush_if = redirect_s;
`endif

endmodule
